vga_scan_timing: RTL and testbench
==================================

// Module: vga_scan_timing
// PURPOSE
//  Raster timing generator for a standard 640x480@60 VGA display, clocked by the 25 MHz pixel clock.
//  Produces hSync/vSync, the active-video flag, current pixel coordinates, a linear pixel address
//  and a once-per-frame screenEnd pulse.
//  Feeds the controller's image/palette RAM address path and the sprite/dot overlay compare logic.
// PARAMETERS
//  WIDTH          640  visible pixels per line
//  HEIGHT         480  visible lines per frame
//  H_FRONT_PORCH  16   pixel clocks after last visible pixel, before hSync
//  H_SYNC_WIDTH   96   hSync pulse length (pixel clocks)
//  H_BACK_PORCH   48   pixel clocks after hSync, before pixel 0
//  V_FRONT_PORCH  10   lines after last visible line, before vSync
//  V_SYNC_WIDTH   2    vSync pulse length (lines)
//  V_BACK_PORCH   33   lines after vSync, before line 0
//  ADDR_WIDTH     20   width of addr ($clog2(WIDTH*HEIGHT)+1)
// PORTS
//  clk25      in   1           pixel clock (25 MHz); all logic on its rising edge
//  reset      in   1           synchronous, active-high reset
//  hSync      out  1           horizontal sync (active-low by default)
//  vSync      out  1           vertical sync (active-low by default)
//  active     out  1           1 while the current pixel is visible
//  screenEnd  out  1           one-cycle pulse at the start of vertical blanking
//  x          out  10          horizontal counter, 0..H_TOTAL-1
//  y          out  9           vertical counter, low 9 bits
//  addr       out  ADDR_WIDTH  x + WIDTH*y, linear pixel index for the image RAM
// BEHAVIOUR
//  - H_TOTAL = WIDTH+HFP+HSW+HBP = 800.
//  - V_TOTAL = HEIGHT+VFP+VSW+VBP = 525.
//  - Internal registers: hCount[9:0] and vCount[9:0].
//  - Each clk25 cycle hCount increments.
//  - At hCount==H_TOTAL-1, hCount wraps to 0 and vCount increments.
//  - At hCount==H_TOTAL-1 && vCount==V_TOTAL-1, both counters wrap to 0 (new frame).
//  - reset=1 at a rising edge: hCount=vCount=0, overriding any increment, including mid-line or mid-sync.
//  - While reset is held, both counters stay at 0.
//  - All outputs are combinational decodes of the counter registers, with zero latency relative to the counters.
//  - x = hCount.
//  - y = vCount[8:0]. Lines 512..524 alias to 0..12; consumers must qualify with active.
//  - active = (hCount < WIDTH) && (vCount < HEIGHT).
//  - hSync is asserted (0) when WIDTH+HFP <= hCount < WIDTH+HFP+HSW, i.e. 656..751; otherwise 1.
//  - vSync is asserted (0) when HEIGHT+VFP <= vCount < HEIGHT+VFP+VSW, i.e. 490..491; otherwise 1.
//  - screenEnd = (hCount==0 && vCount==HEIGHT): exactly one cycle per frame (line 480, pixel 0).
//  - addr = hCount + WIDTH*vCount, computed at ADDR_WIDTH with no truncation inside the visible area.
//    - Only meaningful while active=1; value in blanking is unconstrained.
//  - Outputs while reset is held: x=0, y=0, addr=0, active=1, hSync=1, vSync=1, screenEnd=0.
//  - Frame period: 420000 clk25 cycles.
// CONFIGURATION
//  - VGA_SYNC_ACTIVE_HIGH_EN defined: hSync/vSync are asserted high (1 inside the sync windows, 0 outside).
//    - Reset values then become hSync=0, vSync=0.
//  - VGA_SYNC_ACTIVE_HIGH_EN undefined (default): sync pulses are active-low as specified above.
//  - No other behaviour changes with the macro.
// TESTING
//  1. Reset for 3 cycles, then release.
//     -> x=0, y=0, active=1, hSync=1, vSync=1, screenEnd=0.
//     -> After 639 cycles: x=639, active=1. Next cycle: x=640, active=0.
//  2. Run one line from reset release.
//     -> hSync is low for exactly 96 cycles, x=656..751.
//     -> x wraps 799->0 and y increments 0->1 on the same edge.
//  3. Run a full frame.
//     -> screenEnd pulses once, at y=480, x=0.
//     -> vSync is low only for lines 490 and 491 (1600 cycles).
//     -> Counters return to x=0, y=0 after 420000 cycles.
//  4. Check the address decode.
//     -> At x=5, y=2: addr=1285.
//     -> At x=639, y=479: addr=307199.
//     -> active=1 for exactly 307200 cycles per frame.
//  5. Assert reset at x=700, y=300 for one cycle.
//     -> Next cycle: x=0, y=0, hSync=1; counting resumes normally.
//  6. Rebuild with VGA_SYNC_ACTIVE_HIGH_EN.
//     -> hSync=1 for x=656..751, 0 elsewhere.
//     -> vSync=1 only on lines 490..491.

Source files
------------

// File: rtl/vga_scan_timing.sv
// ============================================================================
// vga_scan_timing
// ----------------------------------------------------------------------------
// Raster timing generator for a 640x480@60 VGA display running on the 25 MHz
// pixel clock. A horizontal and a vertical counter walk the full 800x525
// raster; every output is a zero-latency combinational decode of those two
// registers, so x/y/addr/active/hSync/vSync/screenEnd all describe the same
// pixel in the same cycle.
//
// Ports
//   clk25      in   1           pixel clock, all logic on its rising edge
//   reset      in   1           synchronous active-high reset
//   hSync      out  1           horizontal sync pulse
//   vSync      out  1           vertical sync pulse
//   active     out  1           current pixel lies in the visible area
//   screenEnd  out  1           one-cycle pulse at line HEIGHT, pixel 0
//   x          out  10          horizontal counter, 0..H_TOTAL-1
//   y          out  9           low 9 bits of the vertical counter
//   addr       out  ADDR_WIDTH  x + WIDTH*y, linear image RAM index
//
// Configuration macro
//   VGA_SYNC_ACTIVE_HIGH_EN  when defined, hSync/vSync are driven high inside
//                            their sync windows and low elsewhere. When
//                            undefined (default) the pulses are active-low.
// ============================================================================
module vga_scan_timing #(
    parameter int WIDTH         = 640,
    parameter int HEIGHT        = 480,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_WIDTH  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_WIDTH  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int ADDR_WIDTH    = 20
) (
    input  logic                  clk25,
    input  logic                  reset,
    output logic                  hSync,
    output logic                  vSync,
    output logic                  active,
    output logic                  screenEnd,
    output logic [9:0]            x,
    output logic [8:0]            y,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam int H_TOTAL = WIDTH + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int V_TOTAL = HEIGHT + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    localparam logic [9:0] H_VISIBLE    = 10'(WIDTH);
    localparam logic [9:0] H_SYNC_START = 10'(WIDTH + H_FRONT_PORCH);
    localparam logic [9:0] H_SYNC_STOP  = 10'(WIDTH + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);

    localparam logic [9:0] V_VISIBLE    = 10'(HEIGHT);
    localparam logic [9:0] V_SYNC_START = 10'(HEIGHT + V_FRONT_PORCH);
    localparam logic [9:0] V_SYNC_STOP  = 10'(HEIGHT + V_FRONT_PORCH + V_SYNC_WIDTH);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);

    // Level driven on hSync/vSync while inside the sync window.
`ifdef VGA_SYNC_ACTIVE_HIGH_EN
    localparam logic SYNC_ASSERT = 1'b1;
`else
    localparam logic SYNC_ASSERT = 1'b0;
`endif

    logic [9:0] h_count_q;
    logic [9:0] h_count_d;
    logic [9:0] v_count_q;
    logic [9:0] v_count_d;

    logic       h_last_s;
    logic       v_last_s;
    logic       h_sync_win_s;
    logic       v_sync_win_s;

    assign h_last_s = (h_count_q == H_LAST);
    assign v_last_s = (v_count_q == V_LAST);

    // Next-state for the raster counters: vertical advances only on line wrap.
    always_comb begin
        h_count_d = h_count_q;
        v_count_d = v_count_q;
        if (h_last_s) begin
            h_count_d = 10'd0;
            if (v_last_s) begin
                v_count_d = 10'd0;
            end else begin
                v_count_d = v_count_q + 10'd1;
            end
        end else begin
            h_count_d = h_count_q + 10'd1;
        end
    end

    // Counter registers; reset wins over any increment, mid-line or mid-sync.
    always_ff @(posedge clk25) begin
        if (reset) begin
            h_count_q <= 10'd0;
            v_count_q <= 10'd0;
        end else begin
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
        end
    end

    assign h_sync_win_s = (h_count_q >= H_SYNC_START) && (h_count_q < H_SYNC_STOP);
    assign v_sync_win_s = (v_count_q >= V_SYNC_START) && (v_count_q < V_SYNC_STOP);

    // Output decode, all derived from the current counter values.
    always_comb begin
        x         = h_count_q;
        // Lines 512..524 alias to 0..12 here; consumers qualify with active.
        y         = v_count_q[8:0];
        active    = (h_count_q < H_VISIBLE) && (v_count_q < V_VISIBLE);
        screenEnd = (h_count_q == 10'd0) && (v_count_q == V_VISIBLE);
        if (h_sync_win_s) begin
            hSync = SYNC_ASSERT;
        end else begin
            hSync = ~SYNC_ASSERT;
        end
        if (v_sync_win_s) begin
            vSync = SYNC_ASSERT;
        end else begin
            vSync = ~SYNC_ASSERT;
        end
        // Widened before the multiply so no product bits are lost.
        addr = ADDR_WIDTH'(h_count_q)
             + (ADDR_WIDTH'(v_count_q) * ADDR_WIDTH'(WIDTH));
    end

endmodule

// File: tb/tb_vga_scan_timing.sv
// ============================================================================
// tb_vga_scan_timing
// ----------------------------------------------------------------------------
// Two instances share one clock: the standard 640x480 timing for line-level
// checks, and a miniature raster (16x8 visible, 24x15 total) so that whole
// frames fit in a short run. Expected samples and window counts are queued by
// the stimulus process; a monitor pops them at the matching cycle.
// ============================================================================
module tb_vga_scan_timing;

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
    localparam logic SA = 1'b1;
`else
    localparam logic SA = 1'b0;
`endif

    typedef struct {
        int          cyc;
        int          kind;   // 0 sample, 1 hs cnt, 2 vs cnt, 3 act cnt, 4 se cnt, 5 clear
        int          sel;    // 0 full-size instance, 1 miniature instance
        logic [9:0]  x;
        logic [8:0]  y;
        logic [19:0] addr;
        bit          chk_addr;
        logic        act;
        logic        hs;
        logic        vs;
        logic        se;
        int          cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    logic        clk;
    logic        rst_w [2];
    logic        hs_w  [2];
    logic        vs_w  [2];
    logic        act_w [2];
    logic        se_w  [2];
    logic [9:0]  x_w   [2];
    logic [8:0]  y_w   [2];
    logic [19:0] addr_w[2];

    int cyc;
    int n_total;
    int n_pass;
    int c_hs [2];
    int c_vs [2];
    int c_act[2];
    int c_se [2];

    vga_scan_timing u_full (
        .clk25(clk), .reset(rst_w[0]),
        .hSync(hs_w[0]), .vSync(vs_w[0]), .active(act_w[0]), .screenEnd(se_w[0]),
        .x(x_w[0]), .y(y_w[0]), .addr(addr_w[0])
    );

    vga_scan_timing #(
        .WIDTH(16), .HEIGHT(8),
        .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .H_BACK_PORCH(3),
        .V_FRONT_PORCH(2), .V_SYNC_WIDTH(2), .V_BACK_PORCH(3),
        .ADDR_WIDTH(20)
    ) u_mini (
        .clk25(clk), .reset(rst_w[1]),
        .hSync(hs_w[1]), .vSync(vs_w[1]), .active(act_w[1]), .screenEnd(se_w[1]),
        .x(x_w[1]), .y(y_w[1]), .addr(addr_w[1])
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_s(input int c, input int s, input int ex, input int ey,
                          input int ea, input bit chk, input bit act, input bit hw,
                          input bit vw, input bit se, input string nm);
        exp_t e;
        e.cyc = c; e.kind = 0; e.sel = s;
        e.x = 10'(ex); e.y = 9'(ey); e.addr = 20'(ea); e.chk_addr = chk;
        e.act = act; e.hs = hw ? SA : ~SA; e.vs = vw ? SA : ~SA; e.se = se;
        e.cnt = 0;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic push_c(input int c, input int s, input int kind, input int n,
                          input string nm);
        exp_t e;
        e = '{default: 0};
        e.cyc = c; e.kind = kind; e.sel = s; e.cnt = n;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare queued expectations at their cycle, then accumulate counts.
    initial begin
        exp_t  e;
        string nm;
        int    got;
        bit    ok;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.cyc < cyc) begin
                    n_total++;
                    $display("FAIL %s: check missed, now cycle %0d, required cycle %0d", nm, cyc, e.cyc);
                end else if (e.kind == 5) begin
                    c_hs[e.sel] = 0; c_vs[e.sel] = 0; c_act[e.sel] = 0; c_se[e.sel] = 0;
                end else if (e.kind == 0) begin
                    n_total++;
                    ok = (x_w[e.sel] === e.x) && (y_w[e.sel] === e.y) &&
                         (act_w[e.sel] === e.act) && (hs_w[e.sel] === e.hs) &&
                         (vs_w[e.sel] === e.vs) && (se_w[e.sel] === e.se) &&
                         (!e.chk_addr || (addr_w[e.sel] === e.addr));
                    if (ok) n_pass++;
                    else $display("FAIL %s: got x=%0d y=%0d addr=%0d act=%b hs=%b vs=%b se=%b, want x=%0d y=%0d addr=%0d(chk=%0d) act=%b hs=%b vs=%b se=%b",
                                  nm, x_w[e.sel], y_w[e.sel], addr_w[e.sel], act_w[e.sel],
                                  hs_w[e.sel], vs_w[e.sel], se_w[e.sel], e.x, e.y, e.addr,
                                  e.chk_addr, e.act, e.hs, e.vs, e.se);
                end else begin
                    n_total++;
                    case (e.kind)
                        1:       got = c_hs[e.sel];
                        2:       got = c_vs[e.sel];
                        3:       got = c_act[e.sel];
                        default: got = c_se[e.sel];
                    endcase
                    if (got == e.cnt) n_pass++;
                    else $display("FAIL %s: got count %0d, want %0d", nm, got, e.cnt);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (hs_w[i] === SA)    c_hs[i]++;
                if (vs_w[i] === SA)    c_vs[i]++;
                if (act_w[i] === 1'b1) c_act[i]++;
                if (se_w[i] === 1'b1)  c_se[i]++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Stimulus: directed reset/run sequence, expectations queued up front.
    initial begin
        int b;
        int s;
        cyc = 0; n_total = 0; n_pass = 0;
        rst_w[0] = 1'b1;
        rst_w[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        b = cyc;
        push_c(b, 0, 5, 0, "f_clear");
        push_s(b + 0,    0, 0,   0, 0,    1, 1, 0, 0, 0, "f_reset_state");
        push_s(b + 639,  0, 639, 0, 639,  1, 1, 0, 0, 0, "f_last_visible");
        push_s(b + 640,  0, 640, 0, 0,    0, 0, 0, 0, 0, "f_first_blank");
        push_s(b + 655,  0, 655, 0, 0,    0, 0, 0, 0, 0, "f_hs_before");
        push_s(b + 656,  0, 656, 0, 0,    0, 0, 1, 0, 0, "f_hs_start");
        push_s(b + 751,  0, 751, 0, 0,    0, 0, 1, 0, 0, "f_hs_end");
        push_s(b + 752,  0, 752, 0, 0,    0, 0, 0, 0, 0, "f_hs_after");
        push_s(b + 799,  0, 799, 0, 0,    0, 0, 0, 0, 0, "f_line_end");
        push_s(b + 800,  0, 0,   1, 640,  1, 1, 0, 0, 0, "f_line_wrap");
        push_c(b + 800,  0, 1, 96,  "f_hs_count_line");
        push_c(b + 800,  0, 2, 0,   "f_vs_count_line");
        push_c(b + 800,  0, 3, 640, "f_act_count_line");
        push_s(b + 1605, 0, 5,   2, 1285, 1, 1, 0, 0, 0, "f_addr_5_2");
        push_s(b + 2300, 0, 700, 2, 0,    0, 0, 1, 0, 0, "f_pre_reset");
        push_s(b + 2301, 0, 0,   0, 0,    1, 1, 0, 0, 0, "f_after_reset");
        push_s(b + 2302, 0, 1,   0, 1,    1, 1, 0, 0, 0, "f_resume");
        push_s(b + 2957, 0, 656, 0, 0,    0, 0, 1, 0, 0, "f_resume_hs");
        @(negedge clk);
        rst_w[0] = 1'b0;
        wait_to(b + 2300);
        @(negedge clk);
        rst_w[0] = 1'b1;
        wait_to(b + 2301);
        @(negedge clk);
        rst_w[0] = 1'b0;
        wait_to(b + 2958);

        // Miniature raster: H_TOTAL 24 (sync 18..20), V_TOTAL 15 (sync lines 10..11).
        s = cyc;
        push_c(s, 1, 5, 0, "s_clear");
        push_s(s + 0,   1, 0,  0,  0,   1, 1, 0, 0, 0, "s_reset_state");
        push_s(s + 17,  1, 17, 0,  0,   0, 0, 0, 0, 0, "s_hs_before");
        push_s(s + 18,  1, 18, 0,  0,   0, 0, 1, 0, 0, "s_hs_start");
        push_s(s + 21,  1, 21, 0,  0,   0, 0, 0, 0, 0, "s_hs_after");
        push_s(s + 183, 1, 15, 7,  127, 1, 1, 0, 0, 0, "s_addr_last");
        push_s(s + 184, 1, 16, 7,  0,   0, 0, 0, 0, 0, "s_blank");
        push_s(s + 191, 1, 23, 7,  0,   0, 0, 0, 0, 0, "s_pre_se");
        push_s(s + 192, 1, 0,  8,  0,   0, 0, 0, 0, 1, "s_screen_end");
        push_s(s + 193, 1, 1,  8,  0,   0, 0, 0, 0, 0, "s_post_se");
        push_s(s + 239, 1, 23, 9,  0,   0, 0, 0, 0, 0, "s_vs_before");
        push_s(s + 240, 1, 0,  10, 0,   0, 0, 0, 1, 0, "s_vs_start");
        push_s(s + 287, 1, 23, 11, 0,   0, 0, 0, 1, 0, "s_vs_last");
        push_s(s + 288, 1, 0,  12, 0,   0, 0, 0, 0, 0, "s_vs_after");
        push_s(s + 359, 1, 23, 14, 0,   0, 0, 0, 0, 0, "s_frame_last");
        push_s(s + 360, 1, 0,  0,  0,   1, 1, 0, 0, 0, "s_frame_wrap");
        push_c(s + 360, 1, 1, 45,  "s_hs_count_frame");
        push_c(s + 360, 1, 2, 48,  "s_vs_count_frame");
        push_c(s + 360, 1, 3, 128, "s_act_count_frame");
        push_c(s + 360, 1, 4, 1,   "s_se_count_frame");
        @(negedge clk);
        rst_w[1] = 1'b0;
        wait_to(s + 362);
        @(negedge clk);

        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d pending checks, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
